video_sink_fifo: RTL

VIDEO_SINK_FIFO -- requirements
Module: video_sink_fifo

---
 rtl/video_sink_fifo_pkg.sv | 15 +
 rtl/vga.svh | 22 ++
 rtl/vga_fifo_sync.sv | 48 ++++
 rtl/video_sink_fifo.sv | 106 ++++++++++
 4 files changed

// File: rtl/video_sink_fifo_pkg.sv
// Types and widths for the video sink FIFO. Re-exports the shared VGA pixel
// definitions as package items so that other files need no macros.
package video_sink_fifo_pkg;
  `include "vga.svh"

  localparam int R_W   = `R_SIZE;
  localparam int G_W   = `G_SIZE;
  localparam int B_W   = `B_SIZE;
  localparam int RGB_W = `RGB_SIZE;

  typedef enum logic {
    SYNC = 1'b0,  // hunting for a frame-start pixel
    RUN  = 1'b1   // locked to the sync generator
  } sink_state_t;
endpackage

// File: rtl/vga.svh
// Shared VGA pixel definitions: coordinate widths, colour widths and the
// pixel frame passed down the render pipeline.
`ifndef VGA_SVH
`define VGA_SVH

`define H_SIZE   10
`define V_SIZE   10
`define R_SIZE   4
`define G_SIZE   4
`define B_SIZE   4
`define RGB_SIZE (`R_SIZE + `G_SIZE + `B_SIZE)

typedef struct packed {
  logic [`H_SIZE-1:0] hc;
  logic [`V_SIZE-1:0] vc;
  logic               start;  // first active pixel of a frame
  logic [`R_SIZE-1:0] r;
  logic [`G_SIZE-1:0] g;
  logic [`B_SIZE-1:0] b;
} vga_frame_t;

`endif

// File: rtl/vga_fifo_sync.sv
// Show-ahead synchronous FIFO. The head entry is presented on rdata whenever
// the FIFO is non-empty; a pop consumes it on the next rising edge.
// Ports: clk, rst (sync, active-high), push/wdata, pop, rdata, empty, count.
// Push while full and pop while empty are ignored.
module vga_fifo_sync #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage is deliberately not reset.
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/video_sink_fifo.sv
// Video sink: buffers pixels from the render pipeline and hands them to the
// VGA sync generator, locking the two together on the frame-start pixel.
// Ports: clk, rst (sync, active-high); source_vld/source_frame in, stall out
// (back-pressure); vga_req/vga_frame_start in; vga_r/g/b registered colour;
// underflow/align_err one-cycle error pulses; synced high while locked.
module video_sink_fifo
  import video_sink_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           source_vld,
  input  vga_frame_t     source_frame,
  output logic           stall,
  input  logic           vga_req,
  input  logic           vga_frame_start,
  output logic [R_W-1:0] vga_r,
  output logic [G_W-1:0] vga_g,
  output logic [B_W-1:0] vga_b,
  output logic           underflow,
  output logic           align_err,
  output logic           synced
);
  localparam int AW = $clog2(DEPTH);

  sink_state_t      state, state_nxt;
  vga_frame_t       head;
  logic             empty, push, pop;
  logic [AW:0]      count;
  logic [RGB_W-1:0] rgb_nxt;
  logic             uf_nxt, ae_nxt;

  // Stall comes only from the registered count, so the margin absorbs the
  // pixels already in flight when upstream sees it.
  assign stall  = (count >= (AW+1)'(DEPTH - AFULL_MARGIN));
  assign push   = source_vld && !stall;
  assign synced = (state == RUN);

  vga_fifo_sync #(.AW(AW), .DW($bits(vga_frame_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (source_frame),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rgb_nxt   = '0;
    uf_nxt    = 1'b0;
    ae_nxt    = 1'b0;
    case (state)
      SYNC: begin
        // Flush mid-frame pixels until a frame start reaches the head, then
        // wait for the sync generator to ask for the first pixel.
        if (!empty) begin
          if (!head.start) begin
            pop = 1'b1;
          end else if (vga_req && vga_frame_start) begin
            pop       = 1'b1;
            rgb_nxt   = {head.r, head.g, head.b};
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (vga_req) begin
          if (empty) begin
            uf_nxt    = 1'b1;  // takes priority over a start mismatch
            state_nxt = SYNC;
          end else if (head.start != vga_frame_start) begin
            ae_nxt    = 1'b1;  // keep the head; SYNC decides its fate
            state_nxt = SYNC;
          end else begin
            pop     = 1'b1;
            rgb_nxt = {head.r, head.g, head.b};
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= '0;
      underflow             <= 1'b0;
      align_err             <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_nxt;
      underflow             <= uf_nxt;
      align_err             <= ae_nxt;
    end
  end
endmodule
